// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call panel: floor count, sweep-direction
// states and small floor-vector helpers used by the direction logic.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_state_e;

    typedef logic [NUM_FLOORS-1:0] floor_vec_t;
    typedef logic [FLOOR_W-1:0]    floor_idx_t;

    function automatic logic onehot_ok(input floor_vec_t f);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            n = n + {31'd0, f[i]};
        end
        return (n == 32'd1);
    endfunction

    function automatic floor_idx_t floor_index(input floor_vec_t f);
        floor_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (f[i]) idx = floor_idx_t'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    function automatic floor_vec_t above_mask(input floor_idx_t idx);
        floor_vec_t m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > int'(idx));
        end
        return m;
    endfunction

    function automatic floor_vec_t below_mask(input floor_idx_t idx);
        floor_vec_t m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < int'(idx));
        end
        return m;
    endfunction

    // Scanning top-down leaves the lowest set bit as the final winner.
    function automatic floor_idx_t lowest_set(input floor_vec_t v);
        floor_idx_t idx;
        idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (v[i]) idx = floor_idx_t'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    function automatic floor_idx_t highest_set(input floor_vec_t v);
        floor_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i]) idx = floor_idx_t'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    function automatic floor_vec_t idx_onehot(input floor_idx_t idx);
        floor_vec_t r;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            r[i] = (i == int'(idx));
        end
        return r;
    endfunction

endpackage

// File: rtl/call_panel_debounce.sv
// Per-button debouncer: saturating run-length counter of consecutive high
// samples; level is high while the counter sits at DEBOUNCE_CYCLES.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level
);

    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       level_q;

    // Next count: clear on any low sample, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!in) begin
            cnt_d = 8'd0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and registered debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= (cnt_d == LIMIT);
        end
    end

    assign level = level_q;

endmodule

// File: rtl/call_panel.sv
// Elevator floor-call panel: debounces call buttons, latches pending requests
// until served, and picks the next floor with an up/down sweep FSM.
module call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic floor1,
    input  logic floor2,
    input  logic floor3,
    input  logic door,
    input  logic moving,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic target1,
    output logic target2,
    output logic target3,
    output logic dir_up,
    output logic req_valid
);

    floor_vec_t button_s;
    floor_vec_t floor_s;
    floor_vec_t level_s;
    floor_vec_t level_prev_q;
    floor_vec_t rise_s;
    floor_vec_t served_s;
    floor_vec_t pending_q;
    floor_vec_t pending_d;
    floor_vec_t target_q;
    floor_vec_t target_d;
    floor_vec_t above_s;
    floor_vec_t below_s;
    floor_vec_t at_s;
    floor_idx_t cur_s;
    floor_idx_t la_s;
    floor_idx_t hb_s;
    floor_idx_t dist_up_s;
    floor_idx_t dist_dn_s;
    dir_state_e state_q;
    dir_state_e state_d;
    logic       floor_ok_s;
    logic       dir_up_q;
    logic       req_valid_q;

    assign button_s = {button3, button2, button1};
    assign floor_s  = {floor3, floor2, floor1};

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_deb
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .in   (button_s[g]),
            .level(level_s[g])
        );
    end

    // A non-one-hot floor reading can never serve a floor.
    assign floor_ok_s = onehot_ok(floor_s);
    assign served_s   = (floor_ok_s && door && !moving) ? floor_s : '0;
    assign rise_s     = level_s & ~level_prev_q;
    assign pending_d  = (pending_q | (rise_s & ~pending_q)) & ~served_s;

    assign cur_s     = floor_index(floor_s);
    assign above_s   = pending_q & above_mask(cur_s);
    assign below_s   = pending_q & below_mask(cur_s);
    assign at_s      = pending_q & floor_s;
    assign la_s      = lowest_set(above_s);
    assign hb_s      = highest_set(below_s);
    assign dist_up_s = la_s - cur_s;
    assign dist_dn_s = cur_s - hb_s;

    // Sweep direction and next target from the current pending set and floor.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (!floor_ok_s) begin
            state_d  = state_q;
            target_d = target_q;
        end else if (pending_q == '0) begin
            state_d  = IDLE;
            target_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((above_s == '0) && (below_s == '0)) begin
                        state_d  = IDLE;
                        target_d = at_s;
                    end else if ((above_s != '0) && ((below_s == '0) || (dist_up_s <= dist_dn_s))) begin
                        state_d  = UP;
                        target_d = idx_onehot(la_s);
                    end else begin
                        state_d  = DOWN;
                        target_d = idx_onehot(hb_s);
                    end
                end
                UP: begin
                    if (above_s != '0) begin
                        state_d  = UP;
                        target_d = idx_onehot(la_s);
                    end else if (below_s != '0) begin
                        state_d  = DOWN;
                        target_d = idx_onehot(hb_s);
                    end else begin
                        state_d  = IDLE;
                        target_d = at_s;
                    end
                end
                DOWN: begin
                    if (below_s != '0) begin
                        state_d  = DOWN;
                        target_d = idx_onehot(hb_s);
                    end else if (above_s != '0) begin
                        state_d  = UP;
                        target_d = idx_onehot(la_s);
                    end else begin
                        state_d  = IDLE;
                        target_d = at_s;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    target_d = '0;
                end
            endcase
        end
    end

    // Request, direction and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev_q <= '0;
            pending_q    <= '0;
            target_q     <= '0;
            state_q      <= IDLE;
            dir_up_q     <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            level_prev_q <= level_s;
            pending_q    <= pending_d;
            target_q     <= target_d;
            state_q      <= state_d;
            dir_up_q     <= (state_d == UP);
            req_valid_q  <= (pending_d != '0);
        end
    end

    assign led1      = pending_q[0];
    assign led2      = pending_q[1];
    assign led3      = pending_q[2];
    assign target1   = target_q[0];
    assign target2   = target_q[1];
    assign target3   = target_q[2];
    assign dir_up    = dir_up_q;
    assign req_valid = req_valid_q;

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel: expected output vectors are queued as each
// step is driven and popped against the DUT after the step's clock edges.
module tb_call_panel;

    logic clk = 1'b0;
    logic rst;
    logic button1, button2, button3;
    logic floor1, floor2, floor3;
    logic door, moving;
    logic led1, led2, led3;
    logic target1, target2, target3;
    logic dir_up, req_valid;

    int total = 0;
    int bad   = 0;

    string      tag_q[$];
    logic [7:0] exp_q[$];

    wire logic [7:0] obs_s = {led3, led2, led1, target3, target2, target1, dir_up, req_valid};

    call_panel #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .button1  (button1),
        .button2  (button2),
        .button3  (button3),
        .floor1   (floor1),
        .floor2   (floor2),
        .floor3   (floor3),
        .door     (door),
        .moving   (moving),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3),
        .target1  (target1),
        .target2  (target2),
        .target3  (target3),
        .dir_up   (dir_up),
        .req_valid(req_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_out();
        string      t;
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs_s);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs_s === e) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b", t, obs_s, e);
            end
        end
    endtask

    // Vector bits: {led3,led2,led1, target3,target2,target1, dir_up, req_valid}
    initial begin
        rst = 1'b1;
        {button1, button2, button3} = 3'b000;
        {floor1, floor2, floor3}    = 3'b000;
        door = 1'b0; moving = 1'b0;
        step(2);
        push_exp("reset", 8'b000_000_0_0); check_out();
        rst = 1'b0;
        floor1 = 1'b1;

        // Short press below the debounce threshold
        button2 = 1'b1; step(3); button2 = 1'b0; step(3);
        push_exp("short_press", 8'b000_000_0_0); check_out();

        // Held press: led after edge 5, target/dir one edge later
        button2 = 1'b1; step(4);
        push_exp("held_edge4", 8'b000_000_0_0); check_out();
        step(1);
        push_exp("held_edge5", 8'b010_000_0_1); check_out();
        step(1);
        push_exp("held_edge6", 8'b010_010_1_1); check_out();
        step(4);
        push_exp("held_edge10", 8'b010_010_1_1); check_out();
        floor1 = 1'b0; floor2 = 1'b1; door = 1'b1; step(1);
        push_exp("serve2", 8'b000_010_0_0); check_out();
        step(1);
        push_exp("serve2_idle", 8'b000_000_0_0); check_out();
        step(3);
        push_exp("held_single_set", 8'b000_000_0_0); check_out();
        button2 = 1'b0; door = 1'b0; step(1);

        // Equal distance from floor2 prefers UP
        button1 = 1'b1; button3 = 1'b1; step(5);
        push_exp("pend_1_3", 8'b101_000_0_1); check_out();
        step(1);
        push_exp("tie_goes_up", 8'b101_100_1_1); check_out();
        button1 = 1'b0; button3 = 1'b0;

        // At top floor with only lower calls remaining: reverse to DOWN
        floor2 = 1'b0; floor3 = 1'b1; door = 1'b1; step(1);
        push_exp("up_to_down", 8'b001_001_0_1); check_out();
        door = 1'b0;

        // Clear beats a same-cycle set at the served floor
        button3 = 1'b1; step(5);
        push_exp("pend3_set", 8'b101_001_0_1); check_out();
        button3 = 1'b0; step(1);
        button3 = 1'b1; step(4);
        door = 1'b1; step(1);
        push_exp("clear_wins", 8'b001_001_0_1); check_out();
        door = 1'b0; step(2);
        push_exp("held_no_rearm", 8'b001_001_0_1); check_out();
        button3 = 1'b0;

        // Invalid floor readings: FSM holds, nothing gets served
        floor3 = 1'b0; moving = 1'b1; button2 = 1'b1; step(5);
        push_exp("invalid_none", 8'b011_001_0_1); check_out();
        button2 = 1'b0; floor1 = 1'b1; floor2 = 1'b1; moving = 1'b0; door = 1'b1; step(1);
        push_exp("invalid_multi", 8'b011_001_0_1); check_out();
        door = 1'b0; floor1 = 1'b0; step(1);
        push_exp("down_keeps", 8'b011_001_0_1); check_out();

        // Reset mid-operation with a partial press in progress
        button2 = 1'b1; step(2);
        rst = 1'b1; step(1);
        push_exp("mid_reset", 8'b000_000_0_0); check_out();
        rst = 1'b0; step(4);
        push_exp("requalify_edge4", 8'b000_000_0_0); check_out();
        step(1);
        push_exp("requalify_edge5", 8'b010_000_0_1); check_out();
        step(1);
        push_exp("idle_at_cur", 8'b010_010_0_1); check_out();
        door = 1'b1; step(1);
        push_exp("serve_at_cur", 8'b000_010_0_0); check_out();
        step(1);
        push_exp("final_idle", 8'b000_000_0_0); check_out();
        button2 = 1'b0; door = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
